io_responder: RTL and testbench

Memory-mapped bus responder sitting on the far side of the CPU's external data bus (ADDR / Data_BUS_WRITE / CS / WR_RD / Data_BUS_READ). It answers CPU loads and stores, decoded into five word registers: an output FIFO push port, FIFO status, a free-running timer, a scratch register and an identity word. Data pushed into the FIFO drains to an external consumer through a valid/ready handshake. Read data is registered, giving the one-cycle read latency the CPU's memory/write-back stages expect.

---
 rtl/io_responder.sv | 129 ++++++++++++
 tb/tb_io_responder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/io_responder.sv
// Memory-mapped CPU bus responder: output FIFO with valid/ready drain, status,
// free-running timer, scratch and identity registers, with registered one-cycle read data.
module io_responder #(
  parameter int          DEPTH    = 8,
  parameter logic [31:0] ID_VALUE = 32'h10AD_0001
) (
  input  logic        CLK,
  input  logic        Rst,
  input  logic        CS,
  input  logic        WR_RD,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    REG_FIFO    = 3'd0,
    REG_STATUS  = 3'd1,
    REG_TIMER   = 3'd2,
    REG_SCRATCH = 3'd3,
    REG_ID      = 3'd4
  } reg_sel_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          overflow;
  logic [31:0]   timer;
  logic [31:0]   scratch;

  logic [2:0]    sel;
  logic          wr_en;
  logic          rd_en;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic          push_ok;
  logic          ovf_set;
  logic          ovf_clear;
  logic [AW-1:0] next_rd_ptr;
  logic [AW:0]   next_count;
  logic [31:0]   head_next;
  logic [7:0]    count_byte;
  logic [31:0]   status_word;
  logic [31:0]   read_value;
  logic [31:0]   timer_next;

  // Only ADDR[4:2] selects a register; the remaining address bits are don't-care.
  logic unused_addr;
  assign unused_addr = &{1'b0, ADDR[31:5], ADDR[1:0]};

  always_comb begin
    sel         = ADDR[4:2];
    wr_en       = CS & WR_RD;
    rd_en       = CS & ~WR_RD;
    push        = wr_en && (sel == REG_FIFO);
    pop         = out_valid & out_ready;
    full        = (count == FULL_COUNT);
    empty       = (count == '0);
    push_ok     = push & (~full | pop);
    ovf_set     = push & full & ~pop;
    ovf_clear   = wr_en && (sel == REG_STATUS) && Data_BUS_WRITE[2];
    next_rd_ptr = pop ? rd_ptr + AW'(1) : rd_ptr;
    next_count  = count;
    if (push_ok && !pop) next_count = count + (AW+1)'(1);
    if (pop && !push_ok) next_count = count - (AW+1)'(1);

    // The head is registered, so look ahead to the entry that will sit at the
    // read pointer after this edge, bypassing the word being written right now.
    head_next = mem[next_rd_ptr];
    if (push_ok && (wr_ptr == next_rd_ptr)) head_next = Data_BUS_WRITE;
    if (next_count == '0) head_next = '0;

    count_byte  = 8'(count);
    status_word = {16'h0000, count_byte, 5'b00000, overflow, full, empty};

    read_value = '0;
    case (sel)
      REG_STATUS:  read_value = status_word;
      REG_TIMER:   read_value = timer;
      REG_SCRATCH: read_value = scratch;
      REG_ID:      read_value = ID_VALUE;
      default:     read_value = '0;
    endcase

    timer_next = timer + 32'd1;
    if (wr_en && (sel == REG_TIMER)) timer_next = Data_BUS_WRITE;
  end

  // FIFO storage carries no reset; only pointers and count define its contents.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= Data_BUS_WRITE;
  end

  always_ff @(posedge CLK or negedge Rst) begin
    if (!Rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      overflow      <= 1'b0;
      timer         <= '0;
      scratch       <= '0;
      out_data      <= '0;
      out_valid     <= 1'b0;
      Data_BUS_READ <= '0;
    end else begin
      rd_ptr    <= next_rd_ptr;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      count     <= next_count;
      out_data  <= head_next;
      out_valid <= (next_count != '0);
      // A new overflow beats a simultaneous clear request.
      if (ovf_set)        overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
      timer <= timer_next;
      if (wr_en && (sel == REG_SCRATCH)) scratch <= Data_BUS_WRITE;
      if (rd_en) Data_BUS_READ <= read_value;
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: read data and drained FIFO words are checked
// against expected values queued when the stimulus is driven.
module tb_io_responder;

  logic        CLK;
  logic        Rst;
  logic        CS;
  logic        WR_RD;
  logic [31:0] ADDR;
  logic [31:0] Data_BUS_WRITE;
  logic [31:0] Data_BUS_READ;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int vectors    = 0;
  int miscompares = 0;

  logic [31:0] rd_q[$];
  logic [31:0] fifo_q[$];
  logic [31:0] exp_hold;

  localparam int MODEL_DEPTH = 8;

  io_responder #(.DEPTH(8), .ID_VALUE(32'h10AD_0001)) dut (
    .CLK(CLK),
    .Rst(Rst),
    .CS(CS),
    .WR_RD(WR_RD),
    .ADDR(ADDR),
    .Data_BUS_WRITE(Data_BUS_WRITE),
    .Data_BUS_READ(Data_BUS_READ),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One bus cycle. Called at #1 after a rising edge; returns #1 after the next one.
  task automatic apply_stimulus(input logic cs, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic rdy,
                                input logic [31:0] rd_exp);
    bit pop_m;
    CS             = cs;
    WR_RD          = wr;
    ADDR           = addr;
    Data_BUS_WRITE = wdata;
    out_ready      = rdy;
    #1;
    check_output("out_valid", {31'b0, out_valid}, {31'b0, fifo_q.size() != 0});
    pop_m = rdy && (fifo_q.size() != 0);
    if (pop_m) check_output("out_data", out_data, fifo_q[0]);
    if (cs && wr && addr[4:2] == 3'd0) begin
      if (fifo_q.size() < MODEL_DEPTH || pop_m) fifo_q.push_back(wdata);
    end
    if (pop_m) void'(fifo_q.pop_front());
    if (cs && !wr) rd_q.push_back(rd_exp);
    @(posedge CLK);
    #1;
    if (cs && !wr) exp_hold = rd_q.pop_front();
    check_output($sformatf("rdata@%0h", addr), Data_BUS_READ, exp_hold);
  endtask

  initial begin
    Rst = 1'b0; CS = 1'b0; WR_RD = 1'b0; ADDR = '0; Data_BUS_WRITE = '0; out_ready = 1'b0;
    exp_hold = '0;
    #2;
    check_output("reset_rdata", Data_BUS_READ, 32'h0);
    check_output("reset_valid", {31'b0, out_valid}, 32'h0);
    check_output("reset_out_data", out_data, 32'h0);
    @(posedge CLK); #1;
    Rst = 1'b1;

    // FIFO fill past capacity, then drain and clear the sticky overflow
    for (int i = 0; i < 9; i++) apply_stimulus(1, 1, 32'h00, 32'hA0 + i, 0, 0);
    apply_stimulus(1, 0, 32'h04, 0, 0, 32'h0000_0806);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 32'h00, 0, 1, 0);
    apply_stimulus(0, 0, 32'h00, 0, 1, 0);
    apply_stimulus(1, 1, 32'h04, 32'h4, 0, 0);
    apply_stimulus(1, 0, 32'h04, 0, 0, 32'h0000_0001);

    // Push and pop together while full
    for (int i = 0; i < 8; i++) apply_stimulus(1, 1, 32'h00, 32'hB0 + i, 0, 0);
    apply_stimulus(1, 1, 32'h00, 32'hB8, 1, 0);
    apply_stimulus(1, 0, 32'h04, 0, 0, 32'h0000_0802);
    for (int i = 0; i < 8; i++) apply_stimulus(0, 0, 32'h00, 0, 1, 0);
    apply_stimulus(0, 0, 32'h00, 0, 1, 0);

    // Timer load and wrap
    apply_stimulus(1, 1, 32'h08, 32'hFFFF_FFFE, 0, 0);
    apply_stimulus(0, 0, 32'h00, 0, 0, 0);
    apply_stimulus(1, 0, 32'h08, 0, 0, 32'hFFFF_FFFF);
    apply_stimulus(1, 0, 32'h08, 0, 0, 32'h0000_0000);

    // Back-to-back reads, then hold during idle
    apply_stimulus(1, 1, 32'h0C, 32'hDEAD_BEEF, 0, 0);
    apply_stimulus(1, 0, 32'h0C, 0, 0, 32'hDEAD_BEEF);
    apply_stimulus(1, 0, 32'h10, 0, 0, 32'h10AD_0001);
    apply_stimulus(1, 0, 32'h18, 0, 0, 32'h0000_0000);
    apply_stimulus(1, 1, 32'h1C, 32'h1234_5678, 0, 0);
    apply_stimulus(0, 0, 32'h00, 0, 0, 0);
    apply_stimulus(1, 0, 32'h13, 0, 0, 32'h10AD_0001);
    apply_stimulus(0, 0, 32'h00, 0, 0, 0);

    // Mid-run reset with a full FIFO and a loaded timer
    for (int i = 0; i < 8; i++) apply_stimulus(1, 1, 32'h00, 32'hC0 + i, 0, 0);
    apply_stimulus(1, 1, 32'h08, 32'h0000_1234, 0, 0);
    apply_stimulus(1, 0, 32'h08, 0, 0, 32'h0000_1234);
    CS = 1'b1; WR_RD = 1'b0; ADDR = 32'h0C;
    #2;
    Rst = 1'b0;
    #1;
    check_output("midreset_rdata", Data_BUS_READ, 32'h0);
    check_output("midreset_valid", {31'b0, out_valid}, 32'h0);
    check_output("midreset_out_data", out_data, 32'h0);
    fifo_q.delete();
    rd_q.delete();
    exp_hold = '0;
    CS = 1'b0;
    @(posedge CLK); #1;
    Rst = 1'b1;
    apply_stimulus(1, 0, 32'h04, 0, 0, 32'h0000_0001);
    apply_stimulus(1, 0, 32'h08, 0, 0, 32'h0000_0001);
    apply_stimulus(1, 0, 32'h08, 0, 0, 32'h0000_0002);
    apply_stimulus(1, 0, 32'h0C, 0, 0, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
